// File: rtl/mcp_bus_ctrl.sv
// mcp_bus_ctrl: shared flash+SRAM package bus controller.
// Round-robin between two ports; timed setup/strobe/recovery.
module mcp_bus_ctrl #(
  parameter int AB        = 20,
  parameter int W         = 16,
  parameter int T_SETUP   = 1,
  parameter int T_ACC     = 7,
  parameter int T_WP      = 4,
  parameter int T_REC     = 1,
  parameter int BUSY_WAIT = 1
) (
  input  logic            CLK,
  input  logic            XRESET,
  input  logic [1:0]      REQ,
  input  logic [1:0]      WR,
  input  logic [1:0]      SEL,
  input  logic [2*AB-1:0] ADDR,
  input  logic [2*W-1:0]  WDATA,
  input  logic [3:0]      BE,
  output logic [1:0]      ACK,
  output logic [W-1:0]    RDATA,
  output logic [AB-1:0]   MA,
  output logic [W-1:0]    DQ_O,
  output logic            DQ_OE,
  input  logic [W-1:0]    DQ_I,
  output logic            XCEF,
  output logic            XCE1S,
  output logic            CE2S,
  output logic            XOE,
  output logic            XWE,
  output logic            XLB,
  output logic            XUB,
  input  logic            RY_XBY
);

  localparam logic [3:0] SETUP_N = 4'(T_SETUP);
  localparam logic [3:0] ACC_N   = 4'(T_ACC);
  localparam logic [3:0] WP_N    = 4'(T_WP);
  localparam logic [3:0] REC_N   = 4'(T_REC);
  localparam bit         BW      = (BUSY_WAIT != 0);

  typedef enum logic [1:0] {
    IDLE, SETUP, STROBE, REC
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ptr_q, ptr_d;
  logic            gnt_q, gnt_d;
  logic            load;
  logic            wr_q, sel_q;
  logic [AB-1:0]   addr_q;
  logic [1:0]      be_q;
  logic [W-1:0]    wdata_q, rdata_q;
  logic [1:0]      elig;
  logic            flash_busy;
  logic            last_cnt, first_rec;

  assign flash_busy = BW & ~RY_XBY;
  assign elig[0]    = REQ[0] & ~(~SEL[0] & flash_busy);
  assign elig[1]    = REQ[1] & ~(~SEL[1] & flash_busy);
  assign last_cnt   = (cnt_q == 4'd1);
  assign first_rec  = (cnt_q == REC_N);

  assign MA    = addr_q;
  assign DQ_O  = wdata_q;
  assign RDATA = rdata_q;

  // FSM state, phase counter, arbitration pointer
  always_ff @(posedge CLK or negedge XRESET) begin
    if (!XRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  // Capture the granted request so requesters may change after grant
  always_ff @(posedge CLK or negedge XRESET) begin
    if (!XRESET) begin
      wr_q    <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (load) begin
      wr_q    <= gnt_d ? WR[1]  : WR[0];
      sel_q   <= gnt_d ? SEL[1] : SEL[0];
      addr_q  <= gnt_d ? ADDR[2*AB-1:AB] : ADDR[AB-1:0];
      be_q    <= gnt_d ? BE[3:2] : BE[1:0];
      wdata_q <= gnt_d ? WDATA[2*W-1:W] : WDATA[W-1:0];
    end
  end

  // Read data sampled on the edge that ends the output-enable strobe
  always_ff @(posedge CLK or negedge XRESET) begin
    if (!XRESET) begin
      rdata_q <= '0;
    end else if (state_q == STROBE && last_cnt && !wr_q) begin
      rdata_q <= DQ_I;
    end
  end

  // Next state, arbitration and bus strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    load    = 1'b0;
    XCEF    = 1'b1;
    XCE1S   = 1'b1;
    CE2S    = 1'b0;
    XOE     = 1'b1;
    XWE     = 1'b1;
    XLB     = 1'b1;
    XUB     = 1'b1;
    DQ_OE   = 1'b0;
    ACK     = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          gnt_d   = (&elig) ? ptr_q : elig[1];
          ptr_d   = ~gnt_d;
          load    = 1'b1;
          state_d = SETUP;
          cnt_d   = SETUP_N;
        end
      end
      SETUP, STROBE: begin
        XCEF  = sel_q;
        XCE1S = ~sel_q;
        CE2S  = sel_q;
        XLB   = ~(sel_q & be_q[0]);
        XUB   = ~(sel_q & be_q[1]);
        DQ_OE = wr_q;
        if (state_q == STROBE) begin
          XOE = wr_q;
          XWE = ~wr_q;
        end
        if (!last_cnt) begin
          cnt_d = cnt_q - 4'd1;
        end else if (state_q == SETUP) begin
          state_d = STROBE;
          cnt_d   = wr_q ? WP_N : ACC_N;
        end else begin
          state_d = REC;
          cnt_d   = REC_N;
        end
      end
      REC: begin
        if (first_rec) begin
          DQ_OE = wr_q;
          ACK   = gnt_q ? 2'b10 : 2'b01;
        end
        if (last_cnt) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mcp_bus_ctrl.sv
// tb_mcp_bus_ctrl: directed checks of mcp_bus_ctrl
// with default timing (1/7/4/1) and busy-wait enabled.
module tb_mcp_bus_ctrl;

  localparam int AB = 20;
  localparam int W  = 16;

  logic            CLK;
  logic            XRESET;
  logic [1:0]      REQ, WR, SEL, ACK;
  logic [2*AB-1:0] ADDR;
  logic [2*W-1:0]  WDATA;
  logic [3:0]      BE;
  logic [W-1:0]    RDATA, DQ_O, DQ_I;
  logic [AB-1:0]   MA;
  logic            DQ_OE, XCEF, XCE1S, CE2S;
  logic            XOE, XWE, XLB, XUB, RY_XBY;

  mcp_bus_ctrl #(
    .AB(AB), .W(W), .T_SETUP(1), .T_ACC(7),
    .T_WP(4), .T_REC(1), .BUSY_WAIT(1)
  ) dut (
    .CLK(CLK), .XRESET(XRESET), .REQ(REQ), .WR(WR),
    .SEL(SEL), .ADDR(ADDR), .WDATA(WDATA), .BE(BE),
    .ACK(ACK), .RDATA(RDATA), .MA(MA), .DQ_O(DQ_O),
    .DQ_OE(DQ_OE), .DQ_I(DQ_I), .XCEF(XCEF),
    .XCE1S(XCE1S), .CE2S(CE2S), .XOE(XOE), .XWE(XWE),
    .XLB(XLB), .XUB(XUB), .RY_XBY(RY_XBY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus invariants, checked every cycle out of reset
  always @(negedge CLK) begin
    if (XRESET) begin
      check("ce_excl",
            32'(!(!XCEF && !XCE1S && CE2S)), 1);
      check("oe_we_excl", 32'(!(!XOE && !XWE)), 1);
    end
  end

  int c_cef, c_ces, c_oe, c_we, c_dqoe, c_dqbad;
  int c_lbbad, c_ack0, c_ack1, ack_at, ma_first;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic observe(input int n,
                         input logic [1:0] drop,
                         input logic [W-1:0] exp_dq,
                         input logic [1:0] exp_lbub);
    c_cef = 0; c_ces = 0; c_oe = 0; c_we = 0;
    c_dqoe = 0; c_dqbad = 0; c_lbbad = 0;
    c_ack0 = 0; c_ack1 = 0; ack_at = 0; ma_first = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == 1) begin
        REQ = REQ & ~drop;
        ma_first = 32'(MA);
      end
      if (!XCEF) c_cef++;
      if (!XCE1S && CE2S) c_ces++;
      if (!XOE) c_oe++;
      if (!XWE) c_we++;
      if (DQ_OE) begin
        c_dqoe++;
        if (DQ_O !== exp_dq) c_dqbad++;
      end
      if ((!XCEF || !XCE1S) && {XUB, XLB} !== exp_lbub)
        c_lbbad++;
      if (ACK[0]) begin c_ack0++; ack_at = i; end
      if (ACK[1]) begin c_ack1++; ack_at = i; end
    end
  endtask

  int order[$];
  logic [1:0] lo;

  initial begin
    XRESET = 1'b0;
    REQ = '0; WR = '0; SEL = '0; ADDR = '0;
    WDATA = '0; BE = '0; DQ_I = '0; RY_XBY = 1'b1;
    #12;
    check("rst_xcef", 32'(XCEF), 1);
    check("rst_ce1s", 32'({XCE1S, CE2S}), 2);
    check("rst_strb", 32'({XOE, XWE, XLB, XUB}), 15);
    check("rst_dq", 32'({DQ_OE, DQ_O}), 0);
    check("rst_ack", 32'(ACK), 0);
    @(posedge CLK); #1;
    XRESET = 1'b1;
    tick();

    // port 0 SRAM read, upper byte only
    REQ = 2'b01; WR = 2'b00; SEL = 2'b01;
    ADDR[AB-1:0] = 20'h01234; BE = 4'b0010;
    DQ_I = 16'hA55A;
    observe(11, 2'b01, 16'h0, 2'b01);
    check("t1_ces", c_ces, 8);
    check("t1_cef", c_cef, 0);
    check("t1_oe", c_oe, 7);
    check("t1_we", c_we, 0);
    check("t1_dqoe", c_dqoe, 0);
    check("t1_lbub", c_lbbad, 0);
    check("t1_ack0", c_ack0, 1);
    check("t1_ack1", c_ack1, 0);
    check("t1_ackat", ack_at, 9);
    check("t1_ma", ma_first, 32'h1234);
    check("t1_rdata", 32'(RDATA), 32'hA55A);

    // port 1 flash write
    REQ = 2'b10; WR = 2'b10; SEL = 2'b00;
    ADDR[2*AB-1:AB] = 20'h00555;
    WDATA[2*W-1:W] = 16'h00AA; BE = 4'b1100;
    DQ_I = 16'hFFFF;
    observe(9, 2'b10, 16'h00AA, 2'b11);
    check("t2_cef", c_cef, 5);
    check("t2_ces", c_ces, 0);
    check("t2_we", c_we, 4);
    check("t2_oe", c_oe, 0);
    check("t2_dqoe", c_dqoe, 6);
    check("t2_dqval", c_dqbad, 0);
    check("t2_lbub", c_lbbad, 0);
    check("t2_ack1", c_ack1, 1);
    check("t2_ack0", c_ack0, 0);
    check("t2_ackat", ack_at, 6);
    check("t2_ma", ma_first, 32'h555);
    check("t2_rdata", 32'(RDATA), 32'hA55A);

    // both ports continuous: 0 flash read, 1 SRAM write
    REQ = 2'b11; WR = 2'b10; SEL = 2'b10;
    DQ_I = 16'h1357;
    order.delete();
    for (int i = 0; i < 80 && order.size() < 4; i++) begin
      tick();
      if (ACK != 2'b00) order.push_back(32'(ACK[1]));
    end
    REQ = 2'b00;
    check("t3_nack", order.size(), 4);
    while (order.size() < 4) order.push_back(-1);
    check("t3_g0", order[0], 0);
    check("t3_g1", order[1], 1);
    check("t3_g2", order[2], 0);
    check("t3_g3", order[3], 1);
    repeat (2) tick();
    check("t3_rdata", 32'(RDATA), 32'h1357);

    // flash busy: only SRAM port is served
    RY_XBY = 1'b0;
    REQ = 2'b11; WR = 2'b00; SEL = 2'b10;
    DQ_I = 16'hBEEF; BE = 4'b1111;
    observe(14, 2'b10, 16'h0, 2'b00);
    check("t4_ack1", c_ack1, 1);
    check("t4_ack0", c_ack0, 0);
    check("t4_cef", c_cef, 0);
    check("t4_ackat", ack_at, 9);
    RY_XBY = 1'b1;
    tick();
    check("t4_grant0", 32'(XCEF), 0);
    observe(12, 2'b01, 16'h0, 2'b11);
    check("t4_ack0b", c_ack0, 1);
    check("t4_ackatb", ack_at, 8);
    check("t4_rdata", 32'(RDATA), 32'hBEEF);

    // port 0 withdraws while port 1 is busy
    REQ = 2'b10; WR = 2'b10; SEL = 2'b10;
    WDATA[2*W-1:W] = 16'h4242;
    tick();
    REQ = 2'b01;
    repeat (2) tick();
    REQ = 2'b00;
    observe(12, 2'b00, 16'h4242, 2'b00);
    check("t5_ack0", c_ack0, 0);
    check("t5_ack1", c_ack1, 1);
    check("t5_cef", c_cef, 0);

    // reset mid-strobe of a flash write
    REQ = 2'b01; WR = 2'b01; SEL = 2'b00;
    ADDR[AB-1:0] = 20'h0ABCD;
    WDATA[W-1:0] = 16'h5A5A;
    tick();
    REQ = 2'b00;
    repeat (2) tick();
    check("t6_pre_we", 32'(XWE), 0);
    XRESET = 1'b0;
    #1;
    check("t6_we", 32'(XWE), 1);
    check("t6_cef", 32'(XCEF), 1);
    check("t6_dqoe", 32'(DQ_OE), 0);
    check("t6_ack", 32'(ACK), 0);
    check("t6_ma", 32'(MA), 0);
    check("t6_rdata", 32'(RDATA), 0);
    @(posedge CLK); #1;
    XRESET = 1'b1;
    REQ = 2'b11; WR = 2'b00; SEL = 2'b10;
    DQ_I = 16'h0F0F;
    observe(12, 2'b11, 16'h0, 2'b11);
    check("t6_ack0", c_ack0, 1);
    check("t6_ack1", c_ack1, 0);
    check("t6_ackat", ack_at, 9);
    check("t6_cefn", c_cef, 8);
    check("t6_rd", 32'(RDATA), 32'h0F0F);

    lo = 2'b00;
    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mcp_bus_ctrl.md
Name: mcp_bus_ctrl

Overview:
Clocked bus controller for the flash+SRAM multi-chip package. It shares the package's single address/data/strobe bus between two on-chip requesters. It arbitrates round-robin and sequences each access through setup/strobe/recovery phases with parameterised cycle counts. It enforces mutually exclusive chip enables, so flash and SRAM are never selected together, and it holds off flash accesses while the flash reports busy.

Parameters:
AB, 20, memory address width
W, 16, data width
T_SETUP, 1, cycles of chip-enable-only before strobe (1..15)
T_ACC, 7, cycles XOE is low on reads (1..15)
T_WP, 4, cycles XWE is low on writes (1..15)
T_REC, 1, cycles with all strobes inactive after an access (1..15)
BUSY_WAIT, 1, 1: flash requests ineligible while RY_XBY=0; 0: ignore RY_XBY

Ports:
CLK  input  1  controller clock, rising edge
XRESET  input  1  asynchronous active-low reset
REQ  input  2  request per port (bit n = port n)
WR  input  2  1 = write, 0 = read, per port
SEL  input  2  target per port: 0 = flash, 1 = SRAM
ADDR  input  2*AB  address per port, port n at [n*AB +: AB]
WDATA  input  2*W  write data per port
BE  input  4  byte enables per port, port n at [2n +: 2], bit0 = low byte
ACK  output  2  one-cycle completion pulse per port
RDATA  output  W  read data, valid with ACK and held until the next read completes
MA  output  AB  memory address
DQ_O  output  W  write data to the DQ pad
DQ_OE  output  1  DQ pad output enable
DQ_I  input  W  data from the DQ pad
XCEF  output  1  flash chip enable, active low
XCE1S  output  1  SRAM chip enable 1, active low
CE2S  output  1  SRAM chip enable 2, active high
XOE  output  1  output enable, active low
XWE  output  1  write enable, active low
XLB  output  1  SRAM low-byte enable, active low
XUB  output  1  SRAM upper-byte enable, active low
RY_XBY  input  1  flash ready/busy, 0 = busy

Behaviour:
- Reset (asynchronous, immediate, also mid-access):
  - XCEF=1, XCE1S=1, CE2S=0, XOE=1, XWE=1, XLB=1, XUB=1.
  - DQ_OE=0, DQ_O=0, MA=0, ACK=0, RDATA=0.
  - FSM=IDLE; round-robin pointer favours port 0.
  - An interrupted access is dropped and never ACKed.
- Eligibility: REQ[n]=1, and, if SEL[n]=0 and BUSY_WAIT=1, RY_XBY=1. RY_XBY is sampled only in IDLE.
- FSM states: IDLE, SETUP, STROBE, REC. A 4-bit down-counter times each state.
- IDLE:
  - If any port is eligible, grant one: a single eligible port wins; if both are eligible, the pointer port wins. The pointer then moves to the non-granted port.
  - Latch WR/SEL/ADDR/BE/WDATA of the granted port; go to SETUP with count T_SETUP.
  - A REQ dropped before grant is a withdrawal, with no ACK.
- SETUP (T_SETUP cycles):
  - MA = latched address.
  - Chip enable asserted: flash gives XCEF=0; SRAM gives XCE1S=0 and CE2S=1.
  - XLB/XUB = ~BE for SRAM; both held 1 for flash.
  - Writes: DQ_OE=1, DQ_O = latched data.
  - Then STROBE with count T_ACC (read) or T_WP (write).
- STROBE:
  - Chip enable is held.
  - Reads drive XOE=0; DQ_I is captured into RDATA on the edge ending the last STROBE cycle.
  - Writes drive XWE=0.
  - Then REC.
- REC (T_REC cycles):
  - XOE=1, XWE=1, all chip enables inactive, XLB=XUB=1.
  - DQ_OE stays 1 through the first REC cycle (write data hold), then 0.
  - ACK[granted]=1 in the first REC cycle only.
  - Then IDLE.
- Latency: a REQ seen at IDLE edge k gives ACK during cycle k+T_SETUP+Tstrobe+1. Back-to-back accesses re-enter SETUP no earlier than 1 IDLE cycle after REC.
- Invariant: XCEF=0 and (XCE1S=0 and CE2S=1) never hold simultaneously. XOE and XWE are never both 0.
- Requester signals after grant are don't-care. A requester keeping REQ high after ACK is re-eligible and rotates fairly.

Test Plan:
- Reset mid-STROBE of a write -> XWE=1, XCEF=1, DQ_OE=0 immediately; no ACK; first post-reset grant goes to port 0 when both request.
- Port 0 SRAM read, ADDR=0x1234, BE=2'b10, DQ_I=0xA55A, defaults -> XCE1S=0/CE2S=1 for 1+7 cycles, XOE=0 for 7 cycles, XUB=0/XLB=1, ACK[0] 9 cycles after grant edge, RDATA=0xA55A.
- Port 1 flash write, ADDR=0x00555, WDATA=0x00AA -> XCEF=0, XWE=0 for 4 cycles, DQ_O=0x00AA with DQ_OE high through the first REC cycle, XLB=XUB=1, ACK[1] once.
- Both ports REQ continuously (0 flash read, 1 SRAM write) -> grants alternate 0,1,0,1; the two chip enables never overlap.
- RY_XBY=0, port 0 flash read + port 1 SRAM read, BUSY_WAIT=1 -> only port 1 served; port 0 granted in the first IDLE cycle after RY_XBY=1.
- Port 0 REQ pulsed high then low while port 1 is mid-access -> port 0 never granted or ACKed.
